// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring DIV/DIVU sequencer with start/ready handshake and stall request.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor returns 0 after one step instead of 32.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {
        IDLE,
        ON,
`ifdef DIV_ZERO_SHORTCUT_EN
        ZERO,
`endif
        END
    } state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   rem_q, quot_q, dvs_q;
    logic               qneg_q, rneg_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic [WIDTH-1:0]   a_abs, b_abs, rem_d, quot_d, q_fin, r_fin;
    logic [WIDTH:0]     rem_sh;
    logic               ge, accept;
    assign accept = start_i && !annul_i;
    // Divider sees only magnitudes; signs are restored on the final step.
    always_comb begin
        a_abs  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        b_abs  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        rem_sh = {rem_q, quot_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        rem_d  = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], ge};
        q_fin  = qneg_q ? -quot_d : quot_d;
        r_fin  = rneg_q ? -rem_d : rem_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    quot_q <= a_abs;
                    rem_q  <= '0;
                    dvs_q  <= b_abs;
                    qneg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    rneg_q <= signed_div_i && opdata1_i[WIDTH-1];
                    cnt_q  <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
                    state_q <= (opdata2_i == '0) ? ZERO : ON;
`else
                    state_q <= ON;
`endif
                end
`ifdef DIV_ZERO_SHORTCUT_EN
                ZERO: if (annul_i) state_q <= IDLE;
                else begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= END;
                end
`endif
                ON: if (annul_i) state_q <= IDLE;
                else begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_q <= {r_fin, q_fin};
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                END: if (!start_i) begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef DIV_ZERO_SHORTCUT_EN
    assign busy_o = (state_q == IDLE && accept) || state_q == ON || state_q == ZERO;
`else
    assign busy_o = (state_q == IDLE && accept) || state_q == ON;
`endif
    assign result_o = result_q;
    assign ready_o  = ready_q;
endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle divide sequencer for the EX stage of the 5-stage pipeline. It accepts a DIV/DIVU operand pair from EX through a start/ready handshake and runs a 32-step restoring division. It returns {remainder, quotient} for the HI/LO write path. While a divide is in flight it asserts a stall request to the pipeline controller.

## Interface
Parameters:
- WIDTH, 32, operand width. The iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; EX holds it high until ready_o
- annul_i  in  1  abort the current operation (branch/exception flush)
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered
- busy_o  out  1  stall request to the pipeline controller; combinational

## Operation
- Operands are sampled on the edge that accepts start_i. Later changes on opdata*_i are ignored.
- The FSM has four states: IDLE, ZERO, ON, END.
- IDLE:
  - On start_i=1 and annul_i=0: latch operands.
  - If signed, convert each operand to its magnitude (|0x80000000| = 0x80000000 unsigned).
  - Go to ZERO if the divisor is 0 and DIV_ZERO_SHORTCUT_EN is defined; otherwise go to ON with cnt=0.
- ON:
  - Each edge performs one restoring step on a 65-bit register {rem[32:0], quot[31:0]}: shift left 1.
  - If rem ≥ {1'b0, divisor}, subtract the divisor and set quot[0]=1.
  - cnt then increments.
  - On the step where cnt==WIDTH-1:
    - Apply sign fixup when signed: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
    - Register result_o, set ready_o=1, go to END.
- ZERO: next edge sets result_o=0, ready_o=1, goes to END.
- END:
  - While start_i=1, hold result_o and ready_o=1.
  - When start_i=0, the next edge clears ready_o and goes to IDLE.
  - annul_i is ignored in END.
- annul_i=1 in ZERO or ON: next edge goes to IDLE, ready_o stays 0, result_o unchanged.
- busy_o = (state==IDLE & start_i & ~annul_i) | state==ZERO | state==ON.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient wraps to 0x80000000, remainder 0. No trap is raised.

## Timing
- Reset values: state=IDLE, cnt=0, ready_o=0, result_o=0, busy_o=0 (combinational from IDLE with start_i low).
- Count edges from E0, the edge that accepts start_i.
- Normal latency: ready_o rises after edge E32, i.e. 32 edges after acceptance. busy_o is high from the start cycle through the cycle before ready_o.
- Zero-divisor shortcut latency: ready_o rises after E1.
- Minimum gap: after start_i falls, one IDLE cycle passes before the next acceptance.
- rst has priority over everything, including mid-ON and END. Outputs return to reset values on that edge.
- annul_i and start_i arriving together in IDLE: the request is not accepted and busy_o=0.
- start_i dropping during ON without annul_i: the operation completes. ready_o is high for exactly one cycle, then the FSM returns to IDLE.

## Configuration
- DIV_ZERO_SHORTCUT_EN defined: a zero divisor takes the ZERO path. The result is 0 (quotient 0, remainder 0) after 1 edge.
- Undefined: the ZERO state is not compiled. A zero divisor runs the full 32 steps and gives the natural restoring result:
  - Unsigned: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed: the sign fixup applies to that result.

## Test plan
- DIVU 100 / 7, start held → busy_o=1 for 32 cycles; ready_o after E32; result_o = {0x00000002, 0x0000000E}. Drop start → ready_o=0 next cycle.
- DIV -7 (0xFFFFFFF9) / 2 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- DIVU 5 / 0:
  - With the macro: ready_o after E1, result_o = 0.
  - Without the macro: ready_o after E32, result_o = {0x00000005, 0xFFFFFFFF}.
- Accept DIVU 100/7, assert annul_i for one cycle at E10 → IDLE, ready_o never rises, busy_o drops. A new DIVU 9/3 then completes with {0, 3}.
- Pulse rst at E15 of an active divide → all outputs reset. The next divide completes with correct timing.
- Back-to-back: DIVU 20/6, drop start for one cycle, DIVU 21/4 → results {2, 3} then {1, 5}. The second acceptance occurs in the IDLE cycle.
